// File: rtl/addsub_seq_n.sv
// Multi-cycle add/subtract unit: operands are consumed LSB-first, nb_chunk bits
// per clock, with the slice carry held in a register between slices.
module addsub_seq_n #(
    parameter int nb_bit   = 24,
    parameter int nb_chunk = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              sub_i,
    input  logic [nb_bit-1:0] a_i,
    input  logic [nb_bit-1:0] b_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [nb_bit-1:0] result_o,
    output logic              carry_o,
    output logic              ovf_o,
    output logic              lt_o,
    output logic              zero_o
);

    localparam int N  = nb_bit / nb_chunk;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((nb_bit % nb_chunk) != 0) begin : g_bad_chunk
            $error("addsub_seq_n: nb_chunk must divide nb_bit");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [nb_bit-1:0]   r_a;
    logic [nb_bit-1:0]   r_b;
    logic [nb_bit-1:0]   r_work;
    logic                r_sub;
    logic                r_carry;
    logic                r_ready;
    logic                r_done;
    logic [nb_bit-1:0]   r_result;
    logic                r_carry_o;
    logic                r_ovf;
    logic                r_lt;
    logic                r_zero;

    logic [nb_chunk-1:0] w_bb;
    logic [nb_chunk:0]   w_sum;
    logic [nb_bit-1:0]   w_work_next;
    logic                w_accept;
    logic                w_last;
    logic                w_ovf;

    // Operands shift right each RUN cycle, so the active slice is always the low chunk.
    always_comb begin
        w_bb     = r_sub ? ~r_b[nb_chunk-1:0] : r_b[nb_chunk-1:0];
        w_sum    = {1'b0, r_a[nb_chunk-1:0]} + {1'b0, w_bb} + {{nb_chunk{1'b0}}, r_carry};
        w_accept = start_i & r_ready;
        w_last   = (r_cnt == LAST);
        // On the last slice the low chunk of r_a / w_bb holds the original MSBs.
        w_ovf    = (r_a[nb_chunk-1] == w_bb[nb_chunk-1]) &&
                   (w_work_next[nb_bit-1] != r_a[nb_chunk-1]);
    end

    for (genvar k = 0; k < N; k++) begin : g_slice
        assign w_work_next[k*nb_chunk +: nb_chunk] =
            (r_cnt == CW'(k)) ? w_sum[nb_chunk-1:0] : r_work[k*nb_chunk +: nb_chunk];
    end

    // Control FSM, slice datapath and registered visible outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_a       <= {nb_bit{1'b0}};
            r_b       <= {nb_bit{1'b0}};
            r_work    <= {nb_bit{1'b0}};
            r_sub     <= 1'b0;
            r_carry   <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_result  <= {nb_bit{1'b0}};
            r_carry_o <= 1'b0;
            r_ovf     <= 1'b0;
            r_lt      <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_sub   <= sub_i;
                        r_carry <= sub_i;
                        r_cnt   <= {CW{1'b0}};
                        r_ready <= 1'b0;
                        r_state <= S_RUN;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> nb_chunk;
                    r_b     <= r_b >> nb_chunk;
                    r_work  <= w_work_next;
                    r_carry <= w_sum[nb_chunk];
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state   <= S_DONE;
                        r_ready   <= 1'b1;
                        r_done    <= 1'b1;
                        r_result  <= w_work_next;
                        r_carry_o <= r_sub ? ~w_sum[nb_chunk] : w_sum[nb_chunk];
                        r_lt      <= r_sub & ~w_sum[nb_chunk];
                        r_ovf     <= w_ovf;
                        r_zero    <= (w_work_next == {nb_bit{1'b0}});
                    end else begin
                        r_state <= S_RUN;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o  = r_ready;
    assign done_o   = r_done;
    assign result_o = r_result;
    assign carry_o  = r_carry_o;
    assign ovf_o    = r_ovf;
    assign lt_o     = r_lt;
    assign zero_o   = r_zero;

endmodule

// File: tb/tb_addsub_seq_n.sv
// Bench for addsub_seq_n: three builds (nb_chunk = 8, 24, 4) share one stimulus
// stream; each is tracked by an arithmetic model and checked every cycle.
module tb_addsub_seq_n;

    localparam int NB = 24;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        sub   = 1'b0;
    logic [23:0] a     = 24'h0;
    logic [23:0] b     = 24'h0;

    logic [2:0]  w_ready, w_done, w_carry, w_ovf, w_lt, w_zero;
    logic [23:0] w_res [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cnt;

    always #5 clk = ~clk;

    // Returns {result, carry/borrow, signed overflow, unsigned less-than}.
    function automatic logic [26:0] golden(input logic s, input logic [23:0] x, input logic [23:0] y);
        logic [24:0] full;
        logic [23:0] r;
        logic        c, o, l;
        if (s) begin
            r = x - y;
            c = (x < y);
            l = c;
            o = (x[23] != y[23]) && (r[23] != x[23]);
        end else begin
            full = {1'b0, x} + {1'b0, y};
            r = full[23:0];
            c = full[24];
            l = 1'b0;
            o = (x[23] == y[23]) && (r[23] != x[23]);
        end
        return {r, c, o, l};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int CHK = (g == 0) ? 8 : ((g == 1) ? 24 : 4);
        localparam int NR  = NB / CHK;

        addsub_seq_n #(.nb_bit(NB), .nb_chunk(CHK)) u_dut (
            .clk_i    (clk),
            .rst_i    (rst),
            .start_i  (start),
            .sub_i    (sub),
            .a_i      (a),
            .b_i      (b),
            .ready_o  (w_ready[g]),
            .done_o   (w_done[g]),
            .result_o (w_res[g]),
            .carry_o  (w_carry[g]),
            .ovf_o    (w_ovf[g]),
            .lt_o     (w_lt[g]),
            .zero_o   (w_zero[g])
        );

        int          m_left  = 0;
        logic        m_done  = 1'b0;
        logic [23:0] m_res   = 24'h0;
        logic        m_carry = 1'b0;
        logic        m_ovf   = 1'b0;
        logic        m_lt    = 1'b0;
        logic        m_zero  = 1'b0;
        logic [23:0] p_res   = 24'h0;
        logic        p_carry = 1'b0;
        logic        p_ovf   = 1'b0;
        logic        p_lt    = 1'b0;

        // Model: busy for NR edges after an accept, then publish the arithmetic answer.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_left  <= 0;
                m_done  <= 1'b0;
                m_res   <= 24'h0;
                m_carry <= 1'b0;
                m_ovf   <= 1'b0;
                m_lt    <= 1'b0;
                m_zero  <= 1'b0;
            end else begin
                m_done <= 1'b0;
                if (m_left > 1) begin
                    m_left <= m_left - 1;
                end else if (m_left == 1) begin
                    m_left  <= 0;
                    m_done  <= 1'b1;
                    m_res   <= p_res;
                    m_carry <= p_carry;
                    m_ovf   <= p_ovf;
                    m_lt    <= p_lt;
                    m_zero  <= (p_res == 24'h0);
                end else if (start) begin
                    m_left <= NR;
                    {p_res, p_carry, p_ovf, p_lt} <= golden(sub, a, b);
                end
            end
        end

        // Cycle-by-cycle comparison against the model.
        always @(negedge clk) begin
            chk("ready",  g, 32'(w_ready[g]), 32'(m_left == 0));
            chk("done",   g, 32'(w_done[g]),  32'(m_done));
            chk("result", g, 32'(w_res[g]),   32'(m_res));
            chk("carry",  g, 32'(w_carry[g]), 32'(m_carry));
            chk("ovf",    g, 32'(w_ovf[g]),   32'(m_ovf));
            chk("lt",     g, 32'(w_lt[g]),    32'(m_lt));
            chk("zero",   g, 32'(w_zero[g]),  32'(m_zero));
        end
    end

    task automatic run_op(input logic s, input logic [23:0] x, input logic [23:0] y);
        @(negedge clk);
        start = 1'b1; sub = s; a = x; b = y;
        @(negedge clk);
        start = 1'b0; sub = ~s; a = ~x; b = x ^ y;
        repeat (8) @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic [23:0] r, input logic c, input logic o,
                       input logic l, input logic z);
        for (int i = 0; i < 3; i++) begin
            chk({nm, "_res"},   i, 32'(w_res[i]),   32'(r));
            chk({nm, "_carry"}, i, 32'(w_carry[i]), 32'(c));
            chk({nm, "_ovf"},   i, 32'(w_ovf[i]),   32'(o));
            chk({nm, "_lt"},    i, 32'(w_lt[i]),    32'(l));
            chk({nm, "_zero"},  i, 32'(w_zero[i]),  32'(z));
        end
    endtask

    function automatic logic [23:0] pick();
        case ($urandom_range(0, 7))
            0:       return 24'h000000;
            1:       return 24'hFFFFFF;
            2:       return 24'h7FFFFF;
            3:       return 24'h800000;
            default: return 24'($urandom);
        endcase
    endfunction

    initial begin
        chk("gold_sub_5_3",   0, 32'(golden(1'b1, 24'h000005, 24'h000003)), {5'd0, 24'h000002, 3'b000});
        chk("gold_sub_3_5",   0, 32'(golden(1'b1, 24'h000003, 24'h000005)), {5'd0, 24'hFFFFFE, 3'b101});
        chk("gold_add_wrap",  0, 32'(golden(1'b0, 24'hFFFFFF, 24'h000001)), {5'd0, 24'h000000, 3'b100});
        chk("gold_add_ovf",   0, 32'(golden(1'b0, 24'h7FFFFF, 24'h000001)), {5'd0, 24'h800000, 3'b010});

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("rst_ready", i, 32'(w_ready[i]), 32'd1);
        lit("rst", 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Test 1 with latency / ready timing on the nb_chunk=8 build.
        @(negedge clk);
        start = 1'b1; sub = 1'b1; a = 24'h000005; b = 24'h000003;
        @(negedge clk);
        start = 1'b0; a = 24'hABCDEF; b = 24'h123456; sub = 1'b0;
        chk("t1_ready_e0", 0, 32'(w_ready[0]), 32'd0);
        @(negedge clk);
        chk("t1_ready_e1", 0, 32'(w_ready[0]), 32'd0);
        @(negedge clk);
        chk("t1_ready_e2", 0, 32'(w_ready[0]), 32'd0);
        chk("t1_done_e2",  0, 32'(w_done[0]),  32'd0);
        @(negedge clk);
        chk("t1_done_e3",  0, 32'(w_done[0]),  32'd1);
        chk("t1_ready_e3", 0, 32'(w_ready[0]), 32'd1);
        @(negedge clk);
        chk("t1_done_e4",  0, 32'(w_done[0]),  32'd0);
        repeat (6) @(negedge clk);
        lit("t1", 24'h000002, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op(1'b1, 24'h000003, 24'h000005); lit("t2a", 24'hFFFFFE, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op(1'b1, 24'h123456, 24'h123456); lit("t2b", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(1'b0, 24'h00FFFF, 24'h000001); lit("t3a", 24'h010000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 24'hFFFFFF, 24'h000001); lit("t3b", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(1'b0, 24'h7FFFFF, 24'h000001); lit("t4a", 24'h800000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(1'b1, 24'h800000, 24'h000001); lit("t4b", 24'h7FFFFF, 1'b0, 1'b1, 1'b0, 1'b0);

        // start held high, operands changing every cycle: accepts at E0, E4, E8.
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            start = 1'b1; sub = 1'b0;
            a = 24'h100000 + 24'(i * 273);
            b = 24'(i + 1);
            @(negedge clk);
            if (w_done[0]) cnt++;
        end
        start = 1'b0;
        chk("t5_b2b_dones",  0, 32'(cnt), 32'd3);
        chk("t5_b2b_result", 0, 32'(w_res[0]), 32'h100891);
        repeat (8) @(negedge clk);

        // Start pulse at E2 of a running op must be ignored.
        start = 1'b1; sub = 1'b1; a = 24'h00000A; b = 24'h000003;
        cnt = 0;
        @(negedge clk); start = 1'b0; cnt += int'(w_done[0]);
        @(negedge clk); cnt += int'(w_done[0]); start = 1'b1; sub = 1'b0; a = 24'h000001; b = 24'h000001;
        @(negedge clk); cnt += int'(w_done[0]); start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            cnt += int'(w_done[0]);
        end
        chk("t5_ignored_dones",  0, 32'(cnt), 32'd1);
        chk("t5_ignored_result", 0, 32'(w_res[0]), 32'h000007);
        repeat (4) @(negedge clk);

        // Reset during the second RUN cycle.
        start = 1'b1; sub = 1'b0; a = 24'h0000AA; b = 24'h000011;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t6_async_ready", i, 32'(w_ready[i]), 32'd1);
            chk("t6_async_done",  i, 32'(w_done[i]),  32'd0);
        end
        lit("t6_async", 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            cnt += int'(w_done[0]) + int'(w_done[1]) + int'(w_done[2]);
        end
        chk("t6_no_done_after_rst", 0, 32'(cnt), 32'd0);
        run_op(1'b0, 24'h0000AA, 24'h000011); lit("t6_after", 24'h0000BB, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic, start mostly high so the builds run back-to-back.
        for (int i = 0; i < 44000; i++) begin
            start = ($urandom_range(0, 7) != 0);
            sub   = 1'($urandom_range(0, 1));
            a     = pick();
            b     = pick();
            @(negedge clk);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_seq_n.md
Name: addsub_seq_n

Overview:
- Multi-cycle, parametrised add/subtract unit. Successor to the combinational subtractor_n.
- Processes operands LSB-first in nb_chunk-bit slices, one slice per clock, with a ripple carry held in a register between slices.
- Adds an add/sub mode, signed overflow, unsigned less-than and zero flags, and a start/ready/done handshake.
- Sits in datapaths where a full-width single-cycle carry chain breaks timing.

Parameters:
- nb_bit, 24, operand/result width.
- nb_chunk, 8, slice width processed per cycle. Must divide nb_bit; elaboration error otherwise.
- N (localparam), nb_bit/nb_chunk, number of RUN cycles.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  request. Accepted on a rising edge where start_i=1 and ready_o=1.
- sub_i  in  1  mode, sampled with start: 0 = a+b, 1 = a-b.
- a_i  in  nb_bit  operand A, sampled on the accepting edge.
- b_i  in  nb_bit  operand B, sampled on the accepting edge.
- ready_o  out  1  high when a start can be accepted.
- done_o  out  1  one-cycle pulse: result and flags are new.
- result_o  out  nb_bit  a+b or a-b, modulo 2^nb_bit.
- carry_o  out  1  add: carry out. Sub: borrow (1 iff a<b unsigned).
- ovf_o  out  1  two's-complement signed overflow.
- lt_o  out  1  sub: unsigned a<b (= borrow). Add: 0.
- zero_o  out  1  result_o == 0.

Behaviour:
- Reset (rst_i=1, any state, immediate):
  - state=IDLE, slice counter=0.
  - result_o, carry_o, ovf_o, lt_o, zero_o, done_o = 0; ready_o=1.
  - An operation in flight is discarded; no done_o follows.
- FSM states IDLE, RUN, DONE:
  - IDLE: ready_o=1. On the accepting edge:
    - latch a_i, b_i, sub_i;
    - slice carry register := sub_i (the +1 of two's complement);
    - counter := 0; go to RUN.
  - RUN: ready_o=0.
    - Each edge computes slice k = counter: {c, s} = a[k] + (sub ? ~b[k] : b[k]) + carry.
    - Writes s into working-result slice k, carry := c, counter := counter+1.
    - On the edge processing slice N-1, go to DONE and update the visible outputs.
  - DONE: done_o=1 for exactly this one cycle; ready_o=1.
    - start_i=1 here: accepted, go straight to RUN (back-to-back, no IDLE bubble).
    - Otherwise go to IDLE.
- Latency: the accepting edge is E0. done_o is high in the cycle after edge EN. Throughput is one operation per N+1 cycles.
- start_i while ready_o=0 is ignored. Operands and mode are not re-sampled, and the request is not queued.
- Output update: visible outputs are registered and change only on the edge entering DONE. They hold through IDLE and the next RUN until the next completion.
  - result_o := working result.
  - carry_o := sub ? ~c_final : c_final.
  - lt_o := sub ? ~c_final : 0.
  - ovf_o := (a_msb == bb_msb) && (res_msb != a_msb), where bb = sub ? ~b : b.
  - zero_o := (result == 0).
- Inputs a_i, b_i, sub_i may change freely after the accepting edge without affecting the operation.
- nb_chunk == nb_bit (N=1): one RUN cycle; the same rules apply.

Test Plan:
nb_bit=24, nb_chunk=8, N=3 unless stated.
1. sub a=0x000005 b=0x000003 -> result_o=0x000002, carry_o=0, lt_o=0, ovf_o=0, zero_o=0. done_o pulses one cycle after E3; ready_o low during E1..E3.
2. sub a=0x000003 b=0x000005 -> result_o=0xFFFFFE, carry_o=1, lt_o=1, ovf_o=0. Then sub a=b=0x123456 -> result_o=0, zero_o=1, carry_o=0.
3. add a=0x00FFFF b=0x000001 (carry across two slice boundaries) -> result_o=0x010000, carry_o=0. Then add 0xFFFFFF+0x000001 -> result_o=0x000000, carry_o=1, zero_o=1, ovf_o=0.
4. add 0x7FFFFF+0x000001 -> 0x800000, ovf_o=1, carry_o=0. Then sub 0x800000-0x000001 -> 0x7FFFFF, ovf_o=1, lt_o=0.
5. Handshake:
   - start_i held high throughout -> ops accepted at E0, E4, E8; operands changed during RUN have no effect.
   - A start pulse only at E2 of a running op -> ignored; exactly one done_o.
6. Reset mid-operation:
   - Assert rst_i during the 2nd RUN cycle -> all outputs 0 and ready_o=1 without waiting for a clock edge; no done_o after release.
   - A start after release completes normally.
   - Also run 10k random a/b/sub_i against a golden model (carry_o === (a<b) for sub; result === (a-b) mod 2^24), with nb_chunk=24 and nb_chunk=4 builds.
